// File: rtl/gnrl_fifo.sv
// Synchronous valid/ready FIFO with wrap-bit pointers.
// Storage flops are not reset; only the pointers carry reset and flush.
module gnrl_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       i_vld,
  output logic                       i_rdy,
  input  logic [DATA_WIDTH-1:0]      i_dat,
  output logic                       o_vld,
  input  logic                       o_rdy,
  output logic [DATA_WIDTH-1:0]      o_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]           wptr;
  logic [AW:0]           rptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  push;
  logic                  pop;

  // Handshake outputs depend only on the registered pointers.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign count = wptr - rptr;
  assign i_rdy = !full;
  assign o_vld = !empty;
  assign o_dat = mem[rptr[AW-1:0]];

  assign push = i_vld & i_rdy;
  assign pop  = o_vld & o_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: tb/tb_gnrl_fifo.sv
// Directed bench for gnrl_fifo at DEPTH=4, DATA_WIDTH=32.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_gnrl_fifo;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        i_vld;
  logic        i_rdy;
  logic [31:0] i_dat;
  logic        o_vld;
  logic        o_rdy;
  logic [31:0] o_dat;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int compared;
  int mismatched;

  gnrl_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_vld = 1'b1; i_dat = 32'hDEAD_BEEF;
    tick(); tick();
    compared++;
    if (count !== 3'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", count); end
    compared++;
    if (empty !== 1'b1 || o_vld !== 1'b0 || i_rdy !== 1'b1 || full !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags got empty=%b o_vld=%b i_rdy=%b full=%b want 1 0 1 0", empty, o_vld, i_rdy, full);
    end
    rst = 1'b0; i_vld = 1'b0;
    tick();
    compared++;
    if (count !== 3'd0 || o_vld !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_no_write got count=%0d o_vld=%b want 0 0", count, o_vld);
    end
  endtask

  task automatic test_fill();
    o_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_vld = 1'b1; i_dat = 32'hA0 + i;
      tick();
      compared++;
      if (count !== 3'(i + 1)) begin mismatched++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
      compared++;
      if (full !== (i == 3) || i_rdy !== (i != 3)) begin
        mismatched++;
        $display("FAIL fill_full got full=%b i_rdy=%b want %b %b", full, i_rdy, i == 3, i != 3);
      end
    end
    i_dat = 32'hA4;
    tick();
    compared++;
    if (count !== 3'd4 || o_dat !== 32'hA0) begin
      mismatched++;
      $display("FAIL fill_overflow got count=%0d o_dat=%h want 4 a0", count, o_dat);
    end
    i_vld = 1'b0;
  endtask

  task automatic test_drain();
    o_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (o_vld !== 1'b1 || o_dat !== 32'hA0 + i) begin
        mismatched++;
        $display("FAIL drain_order got o_vld=%b o_dat=%h want 1 %h", o_vld, o_dat, 32'hA0 + i);
      end
      tick();
    end
    compared++;
    if (empty !== 1'b1 || o_vld !== 1'b0 || count !== 3'd0) begin
      mismatched++;
      $display("FAIL drain_empty got empty=%b o_vld=%b count=%0d want 1 0 0", empty, o_vld, count);
    end
    o_rdy = 1'b0;
  endtask

  task automatic test_stream();
    i_vld = 1'b1; o_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      i_dat = n;
      if (n > 0) begin
        compared++;
        if (o_vld !== 1'b1 || o_dat !== 32'(n - 1)) begin
          mismatched++;
          $display("FAIL stream_data got o_vld=%b o_dat=%0d want 1 %0d", o_vld, o_dat, n - 1);
        end
      end
      tick();
      compared++;
      if (count !== 3'd1) begin mismatched++; $display("FAIL stream_count got %0d want 1", count); end
    end
    i_vld = 1'b0;
    compared++;
    if (o_dat !== 32'd19) begin mismatched++; $display("FAIL stream_last got %0d want 19", o_dat); end
    tick();
    compared++;
    if (empty !== 1'b1) begin mismatched++; $display("FAIL stream_empty got %b want 1", empty); end
    o_rdy = 1'b0;
  endtask

  task automatic test_full_pop();
    o_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_vld = 1'b1; i_dat = 32'hB0 + i;
      tick();
    end
    compared++;
    if (full !== 1'b1) begin mismatched++; $display("FAIL fullpop_full got %b want 1", full); end
    i_vld = 1'b1; i_dat = 32'hB4; o_rdy = 1'b1;
    tick();
    compared++;
    if (count !== 3'd3 || o_dat !== 32'hB1) begin
      mismatched++;
      $display("FAIL fullpop_poponly got count=%0d o_dat=%h want 3 b1", count, o_dat);
    end
    o_rdy = 1'b0;
    tick();
    compared++;
    if (count !== 3'd4) begin mismatched++; $display("FAIL fullpop_repush got %0d want 4", count); end
    i_vld = 1'b0; o_rdy = 1'b1;
    for (int i = 1; i < 5; i++) begin
      compared++;
      if (o_dat !== 32'hB0 + i) begin
        mismatched++;
        $display("FAIL fullpop_order got %h want %h", o_dat, 32'hB0 + i);
      end
      tick();
    end
    o_rdy = 1'b0;
  endtask

  task automatic test_flush();
    o_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_vld = 1'b1; i_dat = 32'hC0 + i;
      tick();
    end
    compared++;
    if (count !== 3'd3) begin mismatched++; $display("FAIL flush_pre got %0d want 3", count); end
    flush = 1'b1; i_vld = 1'b1; i_dat = 32'hC3; o_rdy = 1'b1;
    tick();
    flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b0;
    compared++;
    if (count !== 3'd0 || empty !== 1'b1 || o_vld !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_clear got count=%0d empty=%b o_vld=%b want 0 1 0", count, empty, o_vld);
    end
    i_vld = 1'b1; i_dat = 32'hD0;
    tick();
    i_vld = 1'b0;
    compared++;
    if (count !== 3'd1 || o_dat !== 32'hD0) begin
      mismatched++;
      $display("FAIL flush_after got count=%0d o_dat=%h want 1 d0", count, o_dat);
    end
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b1; flush = 1'b0; i_vld = 1'b0; o_rdy = 1'b0; i_dat = '0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_pop();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gnrl_fifo.md
# gnrl_fifo

Parameterised synchronous FIFO with valid/ready handshake on both sides. It is the standard buffering stage placed downstream of producer pipeline registers (flop-based stage outputs) and upstream of consumers that can stall. It decouples producer and consumer timing without dropping or duplicating data. Storage uses plain un-reset flops; control state uses reset flops.

## Interface

- `DATA_WIDTH`, 32: payload width in bits.
- `DEPTH`, 4: number of entries. Must be a power of two, ≥ 2.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset; sampled on `clk` rising edge.
- `flush`  input  1  synchronous clear of contents; control state only.
- `i_vld`  input  1  producer presents valid data.
- `i_rdy`  output  1  FIFO can accept data (= !full).
- `i_dat`  input  DATA_WIDTH  producer payload.
- `o_vld`  output  1  FIFO presents valid data (= !empty).
- `o_rdy`  input  1  consumer accepts data.
- `o_dat`  output  DATA_WIDTH  head-of-queue payload.
- `count`  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  output  1  count == DEPTH.
- `empty`  output  1  count == 0.

## Operation

- Push = `i_vld & i_rdy`; pop = `o_vld & o_rdy`.
- Write pointer `wptr` and read pointer `rptr` are each $clog2(DEPTH)+1 bits. The low bits index storage; the MSB is the wrap bit.
- empty when `wptr == rptr`. full when the low bits are equal and the MSBs differ. `count = wptr - rptr`, modulo 2^(AW+1).
- Push: `mem[wptr[AW-1:0]] <= i_dat`; `wptr <= wptr + 1`. Pop: `rptr <= rptr + 1`.
- Pointers wrap naturally at 2^(AW+1). No special case at DEPTH-1 → 0.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- When full, `i_rdy` = 0, so no push is possible even if a pop happens the same cycle. There is no ready pass-through; `i_rdy` depends only on state.
- When empty, `o_vld` = 0, so no pop is possible. There is no write-to-read bypass.
- `o_dat = mem[rptr[AW-1:0]]`. It is combinational from storage and is don't-care while `o_vld` = 0.
- Handshake outputs (`i_rdy`, `o_vld`, `full`, `empty`, `count`) are functions of registered state only. There is no combinational path from `i_vld` or `o_rdy`.
- `flush`: on the next edge, `wptr` and `rptr` are set to 0. Any push or pop in the same cycle is discarded. Storage is not cleared.
- Priority at the clock edge: `rst` > `flush` > push/pop.
- While `o_vld` = 1 and `o_rdy` = 0, `o_dat` stays stable.
- The producer must hold `i_dat` stable while `i_vld` = 1 and `i_rdy` = 0. This is a producer rule; the FIFO does not check it.

## Timing

- Reset values (at the first edge with `rst` = 1): `wptr` = `rptr` = 0, so `count` = 0, `empty` = 1, `full` = 0, `o_vld` = 0, `i_rdy` = 1. Storage is not reset.
- Reset or flush asserted mid-operation discards all contents at that edge. Outputs show the empty state from the following cycle.
- Latency: data pushed at edge N is visible on `o_dat` with `o_vld` = 1 in the cycle after edge N.
- Throughput: 1 transfer per cycle on each side when neither full nor empty.
- Effective capacity is exactly DEPTH entries.

## Test plan

- Reset: hold `rst` = 1 for 2 cycles with `i_vld` = 1 -> `count` = 0, `empty` = 1, `o_vld` = 0, `i_rdy` = 1, and no entry written after release.
- Fill (DEPTH = 4, `o_rdy` = 0): push 0xA0..0xA3 on 4 consecutive cycles -> `count` steps 1,2,3,4; `full` = 1 and `i_rdy` = 0 after the 4th push; a 5th `i_vld` with 0xA4 is not accepted.
- Drain and order: from full, `o_rdy` = 1 for 4 cycles -> `o_dat` = 0xA0, A1, A2, A3; `empty` = 1 afterwards; `o_vld` deasserts in the cycle after the last pop.
- Streaming plus wrap: `i_vld` = `o_rdy` = 1 continuously for 20 pushes of incrementing data starting at 0 -> `count` stays at 1 after the first push; output sequence 0..19 in order with no gaps; pointers wrap at least twice.
- Full plus pop same cycle: at `count` = 4, drive `i_vld` = 1 and `o_rdy` = 1 -> pop only; `count` = 3 next cycle; the next push is accepted.
- Flush: at `count` = 3, assert `flush` together with `i_vld` and `o_rdy` -> next cycle `count` = 0, `empty` = 1; the discarded push never appears on `o_dat`.
